// File: rtl/param_sync_fifo_pkg.sv
// Shared types and defaults for the parameterised synchronous FIFO.
// Covers the read-mode enum, default sizes and the pointer-width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AF_THRESH  = DEF_DEPTH - 2;
  localparam int DEF_AE_THRESH  = 2;

  // A pointer always needs at least one bit, even for DEPTH == 2.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Write/read handshake and status bundle of param_sync_fifo.
// The master side drives requests; the slave side is the FIFO.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/param_sync_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances by one on inc and wraps DEPTH-1 -> 0.
// DEPTH need not be a power of two, so the wrap is an explicit compare.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + PW'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy/threshold flags, error pulses
// and either a registered (STD) or first-word-fall-through (FWFT) read port.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int         DEPTH      = DEF_DEPTH,
  parameter int         AF_THRESH  = DEPTH - 2,
  parameter int         AE_THRESH  = DEF_AE_THRESH,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input logic               clk,
  input logic               rst_n,
  param_sync_fifo_if.slave  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_param_err
    $error("param_sync_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  full_flag;
  logic                  empty_flag;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Flags depend only on the registered count, never on this cycle's requests.
  assign full_flag  = (count_reg == CW'(DEPTH));
  assign empty_flag = (count_reg == '0);

  // A write at full is still taken when a pop frees the slot in the same cycle.
  assign rd_acc = bus.r_en && !empty_flag;
  assign wr_acc = bus.w_en && (!full_flag || rd_acc);

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= bus.w_en && !wr_acc;
      underflow_reg <= bus.r_en && empty_flag;
    end
  end

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[w_ptr] <= bus.data_in;
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_w_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (w_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_r_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (r_ptr)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] data_out_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_out_reg <= '0;
      end else if (rd_acc) begin
        data_out_reg <= mem[r_ptr];
      end
    end

    assign bus.data_out = data_out_reg;
  end else begin : g_fwft
    // Head word is shown directly; zero while there is nothing to show.
    assign bus.data_out = empty_flag ? '0 : mem[r_ptr];
  end

  assign bus.full         = full_flag;
  assign bus.empty        = empty_flag;
  assign bus.almost_full  = (count_reg >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_reg <= CW'(AE_THRESH));
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: an STD and an FWFT instance run the same stimulus in
// lockstep and are compared against a queue model every cycle.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_std ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_fwft ();

  assign bus_std.w_en     = w_en;
  assign bus_std.r_en     = r_en;
  assign bus_std.data_in  = data_in;
  assign bus_fwft.w_en    = w_en;
  assign bus_fwft.r_en    = r_en;
  assign bus_fwft.data_in = data_in;

  param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .MODE(FIFO_STD)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_std)
  );

  param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .MODE(FIFO_FWFT)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fwft)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] std_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input logic exp_ovf, input logic exp_udf);
    int            c;
    logic [DW-1:0] fwft_exp;
    c        = sb.size();
    fwft_exp = (c > 0) ? sb[0] : '0;
    check("count",        32'(bus_std.count),        32'(c));
    check("count_fwft",   32'(bus_fwft.count),       32'(c));
    check("full",         32'(bus_std.full),         32'(c == DEPTH));
    check("empty",        32'(bus_std.empty),        32'(c == 0));
    check("almost_full",  32'(bus_std.almost_full),  32'(c >= AF));
    check("almost_empty", 32'(bus_std.almost_empty), 32'(c <= AE));
    check("overflow",     32'(bus_std.overflow),     32'(exp_ovf));
    check("underflow",    32'(bus_std.underflow),    32'(exp_udf));
    check("ovf_fwft",     32'(bus_fwft.overflow),    32'(exp_ovf));
    check("udf_fwft",     32'(bus_fwft.underflow),   32'(exp_udf));
    check("data_std",     32'(bus_std.data_out),     32'(std_exp));
    check("data_fwft",    32'(bus_fwft.data_out),    32'(fwft_exp));
  endtask

  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    int   c;
    logic rd;
    logic wr;
    logic ovf;
    logic udf;
    w_en    = w;
    data_in = d;
    r_en    = r;
    c   = sb.size();
    rd  = r && (c > 0);
    wr  = w && ((c < DEPTH) || rd);
    ovf = w && !wr;
    udf = r && (c == 0);
    if (rd) std_exp = sb.pop_front();
    if (wr) sb.push_back(d);
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    $display("txn w=%0b r=%0b din=%04h -> count=%0d std_out=%04h fwft_out=%04h ovf=%0b udf=%0b",
             w, r, d, bus_std.count, bus_std.data_out, bus_fwft.data_out,
             bus_std.overflow, bus_std.underflow);
    check_all(ovf, udf);
  endtask

  // Requests are held high during reset to show reset wins.
  task automatic do_reset();
    rst_n   = 1'b0;
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 16'hDEAD;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w_en  = 1'b0;
    r_en  = 1'b0;
    sb.delete();
    std_exp = '0;
    $display("txn reset -> count=%0d std_out=%04h fwft_out=%04h",
             bus_std.count, bus_std.data_out, bus_fwft.data_out);
    check_all(1'b0, 1'b0);
  endtask

  initial begin
    do_reset();

    // Fill to full, then one write too many.
    for (int i = 1; i <= 6; i++) cycle(1'b1, DW'(i), 1'b0);
    // Drain, then one read too many; STD output holds the last word.
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

    // Pointer wrap: 3 in / 3 out, then 5 in / 5 out.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0010 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0020 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Simultaneous read/write at full, then drain.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0030 + i), 1'b0);
    cycle(1'b1, 16'h0100, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Simultaneous read/write at empty.
    cycle(1'b1, 16'h0200, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Single word into empty FIFO, then pop it.
    cycle(1'b1, 16'hABCD, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Reset with three words stored, then a read.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b0);
    do_reset();
    cycle(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
